// File: rtl/pine16_bus_pkg.sv
// Shared types and constants for the Pine16 target-side bus responder.
package pine16_bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    // ad1 carries address[19:16] in its upper nibble; the lower nibble is unused
    localparam int AD1_HI_MSB = 7;
    localparam int AD1_HI_LSB = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        MREQ_R,
        RDATA,
        MREQ_W,
        WDONE
    } state_t;

    // Assemble the full 20-bit bus address from the two pin groups
    function automatic logic [ADDR_W-1:0] bus_addr(input logic [7:0] ad1,
                                                   input logic [DATA_W-1:0] ad0);
        return {ad1[AD1_HI_MSB:AD1_HI_LSB], ad0};
    endfunction

endpackage

// File: rtl/ad_bus_driver.sv
// Tristate owner for the muxed ad0 pins. The FSM supplies a registered drive
// request; oe gates it combinationally so the pins float the moment the CPU
// lifts its read strobe.
module ad_bus_driver
    import pine16_bus_pkg::*;
(
    input  logic              drv,
    input  logic              oe,
    input  logic [DATA_W-1:0] data,
    inout  wire  [DATA_W-1:0] ad,
    output logic [DATA_W-1:0] ad_in
);

    logic en;

    // Drive only while a read-data phase is active and the strobe is still low
    assign en    = drv & ~oe;
    assign ad    = en ? data : {DATA_W{1'bz}};
    assign ad_in = ad;

endmodule

// File: rtl/bus_responder.sv
// Target-side Pine16 bus responder: latches the ALE address, decodes memory
// vs I/O space and runs read/write cycles against a handshaked memory port or
// a single-cycle I/O register port.
module bus_responder
    import pine16_bus_pkg::*;
#(
    parameter int IO_AW = 8
) (
    input  logic              CLK,
    input  logic              RST,
    inout  wire  [DATA_W-1:0] ad0,
    input  logic [7:0]        ad1,
    input  logic              pio,
    input  logic              ale,
    input  logic              oe,
    input  logic              we,
    output logic              rdy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [IO_AW-1:0]  io_addr,
    output logic              io_rd,
    output logic              io_wr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              pio_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              drv_q;
    logic              ale_pend_q;  // ALE seen while a memory request was in flight
    logic              rd_drop_q;   // oe lifted during MREQ_R: discard the result
    logic [DATA_W-1:0] ad_in;
    logic [ADDR_W-1:0] addr_in;
    logic              unused;

    assign addr_in = bus_addr(ad1, ad_in);
    assign unused  = ^ad1[AD1_HI_LSB-1:0];

    // Both write ports share the single captured write-data register
    assign mem_wdata = wdata_q;
    assign io_wdata  = wdata_q;

    ad_bus_driver u_drv (
        .drv   (drv_q),
        .oe    (oe),
        .data  (rdata_q),
        .ad    (ad0),
        .ad_in (ad_in)
    );

    // Bus cycle FSM with all request strobes and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            addr_q     <= '0;
            pio_q      <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            drv_q      <= 1'b0;
            ale_pend_q <= 1'b0;
            rd_drop_q  <= 1'b0;
            rdy        <= 1'b1;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            io_addr    <= '0;
            io_rd      <= 1'b0;
            io_wr      <= 1'b0;
        end else begin
            // I/O strobes are single-cycle pulses
            io_rd <= 1'b0;
            io_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (ale) begin
                        addr_q <= addr_in;
                        pio_q  <= pio;
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (ale) begin
                        addr_q <= addr_in;
                        pio_q  <= pio;
                    end else if (!oe) begin
                        // A read wins even if we is also low
                        if (!pio_q) begin
                            mem_addr   <= addr_q;
                            mem_rd     <= 1'b1;
                            rdy        <= 1'b0;
                            ale_pend_q <= 1'b0;
                            rd_drop_q  <= 1'b0;
                            state      <= MREQ_R;
                        end else begin
                            io_addr <= addr_q[IO_AW-1:0];
                            io_rd   <= 1'b1;
                            drv_q   <= 1'b0;
                            state   <= RDATA;
                        end
                    end else if (!we) begin
                        wdata_q <= ad_in;
                        if (!pio_q) begin
                            mem_addr   <= addr_q;
                            mem_wr     <= 1'b1;
                            rdy        <= 1'b0;
                            ale_pend_q <= 1'b0;
                            state      <= MREQ_W;
                        end else begin
                            io_addr <= addr_q[IO_AW-1:0];
                            io_wr   <= 1'b1;
                            state   <= WDONE;
                        end
                    end
                end
                MREQ_R: begin
                    // The request always runs to its ack; bus events are only noted
                    if (ale) begin
                        addr_q     <= addr_in;
                        pio_q      <= pio;
                        ale_pend_q <= 1'b1;
                    end
                    if (oe) rd_drop_q <= 1'b1;
                    if (mem_ack) begin
                        mem_rd     <= 1'b0;
                        rdy        <= 1'b1;
                        ale_pend_q <= 1'b0;
                        rd_drop_q  <= 1'b0;
                        if (ale || ale_pend_q) begin
                            state <= ADDR;
                        end else if (oe || rd_drop_q) begin
                            state <= IDLE;
                        end else begin
                            rdata_q <= mem_rdata;
                            drv_q   <= 1'b1;
                            state   <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    if (ale) begin
                        addr_q <= addr_in;
                        pio_q  <= pio;
                        drv_q  <= 1'b0;
                        state  <= ADDR;
                    end else if (oe) begin
                        drv_q <= 1'b0;
                        state <= IDLE;
                    end else if (io_rd) begin
                        // io_rdata is only valid during the io_rd cycle
                        rdata_q <= io_rdata;
                        drv_q   <= 1'b1;
                    end
                end
                MREQ_W: begin
                    if (ale) begin
                        addr_q     <= addr_in;
                        pio_q      <= pio;
                        ale_pend_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_wr     <= 1'b0;
                        rdy        <= 1'b1;
                        ale_pend_q <= 1'b0;
                        state      <= (ale || ale_pend_q) ? ADDR : WDONE;
                    end
                end
                WDONE: begin
                    if (ale) begin
                        addr_q <= addr_in;
                        pio_q  <= pio;
                        state  <= ADDR;
                    end else if (we) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
